retospect_cfg_loader: RTL and testbench
=======================================

RETOSPECT_CFG_LOADER -- requirements
Module: retospect_cfg_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 384, total configuration chain length in bits; SHALL be a nonzero multiple of 8.
REQ-002 Parameter NN_PULSE, default 2, width of the neuron-state reset pulse in cycles; SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a full chain load.
REQ-006 in_data  input  8  configuration byte, shifted LSB first.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 cfg_en  output  1  chain shift enable, to the chain config_en.
REQ-010 bs_out  output  1  serial bit into the chain head.
REQ-011 bs_return  input  1  serial bit from the chain tail.
REQ-012 nn_reset  output  1  neuron-state reset, to the chain reset_nn.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 rd_data  output  8  byte displaced from the chain tail (readback).
REQ-016 rd_valid  output  1  one-cycle strobe qualifying rd_data.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT, PULSE, DONE.
REQ-018 IDLE: start=1 SHALL clear the bit counter and move to LOAD; start in any other state SHALL be ignored.
REQ-019 LOAD: in_ready SHALL be 1 and cfg_en 0; in_valid=1 SHALL capture in_data into the shift register and move to SHIFT.
REQ-020 SHIFT: cfg_en SHALL be 1 for exactly 8 consecutive cycles, with bs_out = shift register bit 0 and the register shifting right one bit per cycle.
REQ-021 SHIFT: the bit counter SHALL increment once per cycle and SHALL be wide enough to count to CHAIN_LEN without wrap.
REQ-022 After the 8th SHIFT cycle: if the counter equals CHAIN_LEN, the FSM SHALL move to PULSE; otherwise it SHALL move to LOAD.
REQ-023 in_ready SHALL be 0 outside LOAD, so a byte is never accepted back-to-back with its own shifting.
REQ-024 in_valid low in LOAD SHALL stall with cfg_en=0, so the chain holds its contents.
REQ-025 PULSE: nn_reset SHALL be 1 for exactly NN_PULSE cycles and cfg_en SHALL be 0; the FSM then moves to DONE.
REQ-026 DONE: done SHALL be 1 for one cycle; the FSM then moves to IDLE.
REQ-027 nn_reset and cfg_en SHALL never be high in the same cycle.
REQ-028 Minimum load time SHALL be CHAIN_LEN*9/8 + NN_PULSE + 1 cycles from start to done (zero input stall).
REQ-029 bs_out SHALL be 0 whenever cfg_en is 0.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, counter 0, shift registers 0, in_ready 0, cfg_en 0, bs_out 0, nn_reset 0, busy 0, done 0, rd_data 0, rd_valid 0.
REQ-031 Reset asserted mid-SHIFT SHALL abort the load with no further chain shifts; the chain contents are then undefined and a new start is required.

Configuration
REQ-032 Macro RETOSPECT_CFG_READBACK_EN defined: on each SHIFT cycle, bs_return SHALL be sampled on the same edge on which the chain shifts, LSB first, into a readback register.
REQ-033 With the macro defined, rd_data SHALL present the 8 sampled bits and rd_valid SHALL pulse 1 on the cycle after each 8th SHIFT cycle; there is no backpressure.
REQ-034 Macro absent: rd_data and rd_valid SHALL be tied to 0 and no readback storage SHALL be synthesized; the ports remain present.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding, the default CHAIN_LEN (clockbox 48 bits + 16 cells x 21 bits = 384), and the NN_PULSE default.
REQ-036 A single sub-module, retospect_cfg_serializer (8-bit parallel-in/serial-out, optional serial-in capture), is natural; the FSM and counter remain in the top module.

Verification
REQ-037 CHAIN_LEN=16, start, bytes 0xA5 then 0x3C with in_valid held high -> bs_out sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 with cfg_en high for 16 cycles; nn_reset high for 2 cycles; done 1 cycle; total 21 cycles.
REQ-038 Stall: in_valid deasserted for 5 cycles between bytes -> cfg_en 0 for those 5 cycles, bit stream unchanged, done 5 cycles later than in REQ-037.
REQ-039 Readback (macro on): 16-bit chain model preloaded with 0x1234, load 0xFF,0x00 -> rd_data 0x34 then 0x12, each with a 1-cycle rd_valid; model then holds 0x00FF.
REQ-040 start pulsed during SHIFT -> ignored; exactly CHAIN_LEN cfg_en cycles and one done pulse.
REQ-041 rst_n dropped on the 3rd SHIFT cycle -> all outputs 0 immediately, no further cfg_en; a new start performs a full clean load.
REQ-042 Macro off: a full load -> rd_valid and rd_data remain 0 throughout.

Source files
------------

// File: rtl/retospect_cfg_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM encoding and
// default chain geometry.
package retospect_cfg_loader_pkg;

  localparam int CLOCKBOX_BITS     = 48;
  localparam int CELL_COUNT        = 16;
  localparam int CELL_BITS         = 21;
  localparam int CHAIN_LEN_DEFAULT = CLOCKBOX_BITS + CELL_COUNT * CELL_BITS;
  localparam int NN_PULSE_DEFAULT  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    PULSE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/retospect_cfg_loader_serializer.sv
// 8-bit parallel-in/serial-out shifter with optional capture of the chain tail.
// Capture logic exists only when RETOSPECT_CFG_READBACK_EN is defined.
module retospect_cfg_serializer
  import retospect_cfg_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       last,
  input  logic       ser_in,
  output logic       ser_out,
  output logic [7:0] cap_data,
  output logic       cap_valid
);

  logic [7:0] sr_r;

  // Parallel capture of a new byte, or shift right toward the serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= 8'd0;
    end else if (load) begin
      sr_r <= load_data;
    end else if (shift) begin
      sr_r <= {1'b0, sr_r[7:1]};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign ser_out = sr_r[0];

`ifdef RETOSPECT_CFG_READBACK_EN
  logic [7:0] cap_r;
  logic [7:0] cap_data_r;
  logic       cap_valid_r;
  logic [7:0] cap_next_s;

  // Tail bits enter at the MSB so the first sampled bit lands in bit 0.
  assign cap_next_s = {ser_in, cap_r[7:1]};

  // Sample the tail on every shift edge; publish the byte after its 8th bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r       <= 8'd0;
      cap_data_r  <= 8'd0;
      cap_valid_r <= 1'b0;
    end else begin
      if (shift) begin
        cap_r <= cap_next_s;
      end else begin
        cap_r <= cap_r;
      end
      if (shift && last) begin
        cap_data_r  <= cap_next_s;
        cap_valid_r <= 1'b1;
      end else begin
        cap_data_r  <= cap_data_r;
        cap_valid_r <= 1'b0;
      end
    end
  end

  assign cap_data  = cap_data_r;
  assign cap_valid = cap_valid_r;
`else
  logic unused_s;
  assign unused_s  = ^{ser_in, last};
  assign cap_data  = 8'd0;
  assign cap_valid = 1'b0;
`endif

endmodule

// File: rtl/retospect_cfg_loader.sv
// Loads CHAIN_LEN configuration bits byte-by-byte into a serial chain, then
// pulses the neuron-state reset. Readback gated by RETOSPECT_CFG_READBACK_EN.
module retospect_cfg_loader
  import retospect_cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int NN_PULSE  = NN_PULSE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_en,
  output logic       bs_out,
  input  logic       bs_return,
  output logic       nn_reset,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
  localparam int PULSE_W = (NN_PULSE > 1) ? $clog2(NN_PULSE) : 1;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [CNT_W-1:0]   bit_cnt_s;
  logic [PULSE_W-1:0] pulse_cnt_r;
  logic [PULSE_W-1:0] pulse_cnt_s;
  logic               load_s;
  logic               shift_s;
  logic               last_s;
  logic               ser_bit_s;
  logic               in_ready_r;
  logic               cfg_en_r;
  logic               nn_reset_r;
  logic               busy_r;
  logic               done_r;

  // Next-state, counter update and serializer strobes.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    pulse_cnt_s = pulse_cnt_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          bit_cnt_s = {CNT_W{1'b0}};
          state_s   = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          load_s  = 1'b1;
          state_s = SHIFT;
        end else begin
          state_s = LOAD;
        end
      end
      SHIFT: begin
        shift_s   = 1'b1;
        bit_cnt_s = bit_cnt_r + CNT_W'(1);
        // CHAIN_LEN is a multiple of 8, so the low bits mark byte boundaries.
        if (bit_cnt_r[2:0] == 3'd7) begin
          last_s = 1'b1;
          if (bit_cnt_s == CNT_W'(CHAIN_LEN)) begin
            pulse_cnt_s = {PULSE_W{1'b0}};
            state_s     = PULSE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      PULSE: begin
        if (pulse_cnt_r == PULSE_W'(NN_PULSE - 1)) begin
          state_s = DONE;
        end else begin
          pulse_cnt_s = pulse_cnt_r + PULSE_W'(1);
          state_s     = PULSE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and outputs registered from the next-state decode so the
  // outputs always track the current state without combinational glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      pulse_cnt_r <= {PULSE_W{1'b0}};
      in_ready_r  <= 1'b0;
      cfg_en_r    <= 1'b0;
      nn_reset_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      pulse_cnt_r <= pulse_cnt_s;
      in_ready_r  <= (state_s == LOAD);
      cfg_en_r    <= (state_s == SHIFT);
      nn_reset_r  <= (state_s == PULSE);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_s == DONE);
    end
  end

  retospect_cfg_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (in_data),
    .shift     (shift_s),
    .last      (last_s),
    .ser_in    (bs_return),
    .ser_out   (ser_bit_s),
    .cap_data  (rd_data),
    .cap_valid (rd_valid)
  );

  assign in_ready = in_ready_r;
  assign cfg_en   = cfg_en_r;
  assign bs_out   = cfg_en_r & ser_bit_s;
  assign nn_reset = nn_reset_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Scoreboard bench for retospect_cfg_loader on a 16-bit chain model; the
// readback expectations follow RETOSPECT_CFG_READBACK_EN when it is defined.
module tb_retospect_cfg_loader;

  localparam int CL = 16;
  localparam int NP = 2;
  localparam int NB = CL / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready, cfg_en, bs_out, bs_return, nn_reset, busy, done, rd_valid;
  logic [7:0]    rd_data;

  logic [CL-1:0] chain = '0;
  logic          preload_req = 1'b0;
  logic [CL-1:0] preload_val = '0;
  int            cyc = 0;

  logic          exp_bits [0:4095];
  int            bit_wr = 0, bit_rd = 0;
  logic [7:0]    exp_rd [0:1023];
  int            rd_wr = 0, rd_rd = 0;
  int            start_cyc [0:255];
  int            exp_lat [0:255];
  int            ld_wr = 0, ld_rd = 0;
  logic [CL-1:0] ref_chain = '0;
  int            to_cnt = 0, to_seen = 0;
  int            n_cmp = 0, n_fail = 0;
  int            shift_cnt = 0, pulse_cnt = 0;
  logic          prev_done = 1'b0, rv_due = 1'b0;

  logic [7:0]    stim [0:NB-1];
  int            stl [0:NB-1];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical chain: head at the MSB, tail bit presented on bs_return.
  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (cfg_en) chain <= {bs_out, chain[CL-1:1]};
  end
  assign bs_return = chain[0];

  retospect_cfg_loader #(.CHAIN_LEN(CL), .NN_PULSE(NP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_en(cfg_en), .bs_out(bs_out), .bs_return(bs_return),
    .nn_reset(nn_reset), .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit, byte or done.
  initial begin
    forever begin
      @(negedge clk);
      if (to_cnt != to_seen) begin
        chk("wait_bound", 32'(to_cnt - to_seen), 32'd0);
        to_seen = to_cnt;
      end
      if (!rst_n) begin
        chk("reset_outputs", {17'd0, in_ready, cfg_en, bs_out, nn_reset, busy, done, rd_valid, rd_data}, 32'd0);
        bit_rd = bit_wr; rd_rd = rd_wr; ld_rd = ld_wr;
        shift_cnt = 0; pulse_cnt = 0; prev_done = 1'b0; rv_due = 1'b0;
      end else begin
        chk("phase_exclusive", 32'($countones({in_ready, cfg_en, nn_reset, done}) <= 1), 32'd1);
        if (cfg_en) begin
          if (bit_rd == bit_wr) chk("unexpected_shift", 32'd1, 32'd0);
          else begin
            chk("bs_out", 32'(bs_out), 32'(exp_bits[bit_rd]));
            bit_rd++;
          end
          chk("busy_while_shift", 32'(busy), 32'd1);
          shift_cnt++;
        end else begin
          chk("bs_out_idle", 32'(bs_out), 32'd0);
        end
`ifdef RETOSPECT_CFG_READBACK_EN
        chk("rd_valid_timing", 32'(rd_valid), 32'(rv_due));
        if (rd_valid) begin
          if (rd_rd == rd_wr) chk("unexpected_rd", 32'd1, 32'd0);
          else begin
            chk("rd_data", 32'(rd_data), 32'(exp_rd[rd_rd]));
            rd_rd++;
          end
        end
`else
        chk("rd_tied_off", {23'd0, rd_valid, rd_data}, 32'd0);
`endif
        rv_due = cfg_en && (shift_cnt % 8 == 0);
        if (nn_reset) pulse_cnt++;
        if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
        if (done) begin
          chk("busy_at_done", 32'(busy), 32'd1);
          if (ld_rd == ld_wr) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            chk("load_latency", 32'(cyc - start_cyc[ld_rd]), 32'(exp_lat[ld_rd]));
            chk("shift_count", 32'(shift_cnt), 32'(CL));
            chk("pulse_len", 32'(pulse_cnt), 32'(NP));
            chk("bits_consumed", 32'(bit_wr - bit_rd), 32'd0);
            chk("chain_contents", 32'(chain), 32'(ref_chain));
            ld_rd++;
          end
          shift_cnt = 0;
          pulse_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    ref_chain = v;
  endtask

  // Reference: bits leave LSB first; the byte displaced from the tail is the
  // chain's low byte, and the new byte becomes the chain's high byte.
  task automatic issue_byte(input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      exp_bits[bit_wr] = b[k];
      bit_wr++;
    end
`ifdef RETOSPECT_CFG_READBACK_EN
    exp_rd[rd_wr] = ref_chain[7:0];
    rd_wr++;
`endif
    ref_chain = {b, ref_chain[CL-1:8]};
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_load(input bit spur, input bit abort);
    int lat;
    int n;
    lat = CL * 9 / 8 + NP + 1;
    for (int i = 0; i < NB; i++) lat += stl[i];
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc[ld_wr] = cyc;
    exp_lat[ld_wr] = lat;
    ld_wr++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin to_cnt++; return; end
      repeat (stl[i]) begin @(posedge clk); #1; end
      issue_byte(stim[i]);
      if (i == 0 && abort) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        return;
      end
      if (i == 0 && spur) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    n = 0;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    if (!done) to_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    preload(16'h1234);
    stim[0] = 8'hA5; stim[1] = 8'h3C; stl[0] = 0; stl[1] = 0;
    run_load(1'b0, 1'b0);

    stl[1] = 5;
    run_load(1'b0, 1'b0);

    preload(16'h1234);
    stim[0] = 8'hFF; stim[1] = 8'h00; stl[0] = 0; stl[1] = 0;
    run_load(1'b0, 1'b0);

    stim[0] = 8'($urandom); stim[1] = 8'($urandom);
    run_load(1'b1, 1'b0);

    run_load(1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    preload(16'hBEEF);
    run_load(1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NB; i++) begin
        stim[i] = 8'($urandom);
        stl[i]  = $urandom_range(0, 3);
      end
      run_load(1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
